// File: rtl/fixed_to_float.sv
// Converts a signed two's-complement fixed-point value into an IEEE-754 single by
// shifting the magnitude left one bit per cycle until its MSB is set, then packing the result.
module fixed_to_float #(
  parameter int FRACS = 21,
  parameter int INTS  = 1,
  parameter int WIDTH = INTS + FRACS + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH-1:0] fixedPoint_value,
  output logic             done,
  output logic [31:0]      float_result
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, NORM, PACK, DONE} state_t;

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_mag, w_mag_nx;
  logic [CW-1:0]    r_count, w_count_nx;
  logic             r_sign, w_sign_nx;
  logic [31:0]      r_result, w_result_nx;

  logic [WIDTH-1:0] w_abs;
  logic [WIDTH+21:0] w_mant_ext;
  logic [22:0]      w_mant;
  logic [7:0]       w_exp;

  // Negating the most negative code wraps back onto itself, which is exactly its magnitude.
  assign w_abs      = fixedPoint_value[WIDTH-1] ? ('0 - fixedPoint_value) : fixedPoint_value;
  assign w_mant_ext = {r_mag[WIDTH-2:0], 23'b0};
  assign w_mant     = w_mant_ext[WIDTH+21 -: 23];
  assign w_exp      = 8'(10'(127 + INTS) - 10'(r_count));

  always_comb begin
    w_state_nx  = r_state;
    w_mag_nx    = r_mag;
    w_count_nx  = r_count;
    w_sign_nx   = r_sign;
    w_result_nx = r_result;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_sign_nx  = fixedPoint_value[WIDTH-1];
          w_mag_nx   = w_abs;
          w_count_nx = '0;
          w_state_nx = NORM;
        end
      end
      NORM: begin
        if (r_mag == '0) begin
          w_result_nx = '0;
          w_state_nx  = DONE;
        end else if (r_mag[WIDTH-1]) begin
          w_state_nx = PACK;
        end else begin
          w_mag_nx   = {r_mag[WIDTH-2:0], 1'b0};
          w_count_nx = r_count + 1'b1;
        end
      end
      PACK: begin
        w_result_nx = {r_sign, w_exp, w_mant};
        w_state_nx  = DONE;
      end
      DONE: w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_mag    <= '0;
      r_count  <= '0;
      r_sign   <= 1'b0;
      r_result <= '0;
    end else if (clk_en) begin
      r_state  <= w_state_nx;
      r_mag    <= w_mag_nx;
      r_count  <= w_count_nx;
      r_sign   <= w_sign_nx;
      r_result <= w_result_nx;
    end
  end

  assign done         = (r_state == DONE);
  assign float_result = r_result;

endmodule

// File: tb/tb_fixed_to_float.sv
// Scoreboard bench for fixed_to_float: stimulus pushes expected result and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_fixed_to_float;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [22:0] fixedPoint_value;
  logic        done;
  logic [31:0] float_result;

  fixed_to_float #(.FRACS(21), .INTS(1), .WIDTH(23)) dut (
    .clk              (clk),
    .reset            (reset),
    .clk_en           (clk_en),
    .start            (start),
    .fixedPoint_value (fixedPoint_value),
    .done             (done),
    .float_result     (float_result)
  );

  typedef struct {
    logic [22:0] v;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_done = 0;
  int          n_launch = 0;
  logic [31:0] last_res = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Value = signed input / 2^21; float built from the position of the leading one.
  function automatic void ref_model(input logic [22:0] v, output logic [31:0] f, output int lat);
    int x, m, e;
    logic s;
    x = int'($signed(v));
    s = (x < 0);
    m = s ? -x : x;
    if (m == 0) begin
      f = '0;
      lat = 1;
    end else begin
      e = 0;
      while ((m >> (e + 1)) != 0) e++;
      f = {s, 8'(e - 21 + 127), 23'((m - (1 << e)) << (23 - e))};
      lat = 24 - e;
    end
  endfunction

  task automatic launch(input logic [22:0] v, input int extra);
    exp_t  x;
    int    lat;
    logic [31:0] f;
    @(negedge clk);
    start = 1'b1;
    fixedPoint_value = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    ref_model(v, f, lat);
    x.v = v;
    x.res = f;
    x.cyc = cyc + lat + extra;
    exp_q.push_back(x);
    n_launch++;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout_done got=0 expected=1");
    end
  endtask

  always @(negedge clk) begin
    if (reset && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d result=%h expected no pulse", cyc, float_result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_done++;
        last_res = e.res;
        if (float_result !== e.res) begin
          errors++;
          $display("FAIL result in=%h got=%h expected=%h", e.v, float_result, e.res);
        end
        checks++;
        if (cyc !== e.cyc) begin
          errors++;
          $display("FAIL latency in=%h got_cyc=%0d expected_cyc=%0d", e.v, cyc, e.cyc);
        end
      end
    end
  end

  logic [22:0] directed [7] = '{23'h200000, 23'h400000, 23'h600000, 23'h000001,
                                23'h000000, 23'h3FFFFF, 23'h7FFFFF};

  initial begin
    reset = 1'b0;
    clk_en = 1'b1;
    start = 1'b0;
    fixedPoint_value = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || float_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got done=%b res=%h expected done=0 res=00000000", done, float_result);
    end
    reset = 1'b1;

    foreach (directed[i]) begin
      launch(directed[i], 0);
      wait_done();
    end

    for (int i = 0; i < 40; i++) begin
      logic [22:0] v;
      v = 23'($urandom);
      if (i % 8 == 3) v = 23'($urandom_range(0, 15));
      launch(v, 0);
      wait_done();
    end

    // clk_en stall mid-NORM
    launch(23'h100000, 5);
    @(negedge clk);
    clk_en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || float_result !== last_res) begin
        errors++;
        $display("FAIL freeze got done=%b res=%h expected done=0 res=%h", done, float_result, last_res);
      end
    end
    clk_en = 1'b1;
    wait_done();

    // Restart during NORM must be ignored
    launch(23'h000100, 0);
    @(negedge clk);
    start = 1'b1;
    fixedPoint_value = 23'h600000;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (30) @(negedge clk);

    // Reset mid-NORM aborts
    launch(23'h000001, 0);
    repeat (5) @(negedge clk);
    exp_q.delete();
    n_launch--;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || float_result !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got done=%b res=%h expected done=0 res=00000000", done, float_result);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    launch(23'h200000, 0);
    wait_done();
    repeat (5) @(negedge clk);

    checks++;
    if (n_done !== n_launch || exp_q.size() != 0) begin
      errors++;
      $display("FAIL done_count got=%0d expected=%0d pending=%0d", n_done, n_launch, exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
